apb_req_arbiter: RTL and testbench

- Round-robin arbiter that shares the single APB master request port (transfer/ready/write/addr/wdata/rdata) between N_REQ on-chip requesters, e.g. CPU data port, DMA and debug.
- Sits directly in front of APB_Master.
- Registers the winning request, issues a one-cycle transfer pulse, waits for ready, and returns read data with a per-requester acknowledge pulse.

---
 rtl/apb_arb_pkg.sv | 19 +
 rtl/rr_picker.sv | 44 ++++
 rtl/apb_req_arbiter.sv | 137 +++++++++++++
 tb/tb_apb_req_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB request arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int grant_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int N_REQ_DEFAULT = 4;
    localparam int GRANT_W_DEFAULT = grant_w(N_REQ_DEFAULT);

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: rotate the request vector so the search
// starts just above the last grant, take the lowest set bit, rotate back.
module rr_picker
    import apb_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int GW    = grant_w(N_REQ)
)
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [GW-1:0]    i_last,
    output logic [GW-1:0]    o_win,
    output logic             o_valid
);

    localparam logic [GW-1:0] LAST_IDX = GW'(N_REQ - 1);
    localparam logic [GW:0]   N_WIDE   = (GW + 1)'(N_REQ);

    logic [GW-1:0]      w_start;
    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [GW-1:0]      w_idx;
    logic               w_found;
    logic [GW:0]        w_sum;

    // Rotate, priority-encode from bit 0 of the rotated vector, un-rotate.
    always_comb begin
        w_start = (i_last == LAST_IDX) ? '0 : i_last + 1'b1;
        w_dbl   = {i_req, i_req};
        w_rot   = N_REQ'(w_dbl >> w_start);
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_idx   = GW'(i);
                w_found = 1'b1;
            end
        end
        w_sum   = {1'b0, w_start} + {1'b0, w_idx};
        o_win   = (w_sum >= N_WIDE) ? GW'(w_sum - N_WIDE) : GW'(w_sum);
        o_valid = |i_req;
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master request port among N_REQ
// requesters. The winner's request is latched, a one-cycle transfer pulse is
// issued, and the requester gets a one-cycle ack once the master reports ready.
//
// state | meaning
// IDLE  | waiting for any request; winner latched on leaving
// ISSUE | transfer pulse to the master
// WAIT  | holding latched request until ready; rdata captured on ready
// DONE  | ack pulse to the granted requester
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
)
(
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ-1:0]           req_write_i,
    input  logic [N_REQ*AW-1:0]        req_addr_i,
    input  logic [N_REQ*DW-1:0]        req_wdata_i,
    output logic [N_REQ-1:0]           ack_o,
    output logic [DW-1:0]              rdata_o,
    output logic                       busy_o,
    output logic [$clog2(N_REQ)-1:0]   grant_id_o,
    output logic                       transfer,
    output logic                       write,
    output logic [AW-1:0]              addr,
    output logic [DW-1:0]              wdata,
    input  logic                       ready,
    input  logic [DW-1:0]              rdata
);

    localparam int GW = grant_w(N_REQ);

    arb_state_e     r_state;
    arb_state_e     w_next;
    logic [GW-1:0]  r_grant;
    logic [GW-1:0]  r_last;
    logic           r_write;
    logic [AW-1:0]  r_addr;
    logic [DW-1:0]  r_wdata;
    logic [DW-1:0]  r_rdata;

    logic [GW-1:0]  w_win;
    logic           w_valid;
    logic           w_sel_write;
    logic [AW-1:0]  w_sel_addr;
    logic [DW-1:0]  w_sel_wdata;

    rr_picker #(
        .N_REQ (N_REQ),
        .GW    (GW)
    ) u_picker (
        .i_req   (req_i),
        .i_last  (r_last),
        .o_win   (w_win),
        .o_valid (w_valid)
    );

    // Mux the winning requester's command fields.
    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_win == GW'(k)) begin
                w_sel_write = req_write_i[k];
                w_sel_addr  = req_addr_i[k*AW +: AW];
                w_sel_wdata = req_wdata_i[k*DW +: DW];
            end
        end
    end

    // State register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; ready only matters in WAIT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (ready) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        transfer = (r_state == ISSUE);
        busy_o   = (r_state != IDLE);
        ack_o    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            ack_o[k] = (r_state == DONE) && (r_grant == GW'(k));
        end
    end

    // Request latch on grant, response capture on ready.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_grant <= '0;
            r_last  <= GW'(N_REQ - 1);
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == IDLE && w_valid) begin
                r_grant <= w_win;
                r_write <= w_sel_write;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
            if (r_state == WAIT && ready) begin
                r_rdata <= rdata;
                r_last  <= r_grant;
            end
        end
    end

    assign write      = r_write;
    assign addr       = r_addr;
    assign wdata      = r_wdata;
    assign rdata_o    = r_rdata;
    assign grant_id_o = $clog2(N_REQ)'(r_grant);

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: randomized requesters, a behavioural APB slave,
// and a scoreboard fed by a round-robin reference model.
module tb_apb_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic [N-1:0]      req_i;
    logic [N-1:0]      req_write_i;
    logic [N*AW-1:0]   req_addr_i;
    logic [N*DW-1:0]   req_wdata_i;
    logic [N-1:0]      ack_o;
    logic [DW-1:0]     rdata_o;
    logic              busy_o;
    logic [1:0]        grant_id_o;
    logic              transfer;
    logic              write;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic              ready;
    logic [DW-1:0]     rdata;

    apb_req_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .req_i       (req_i),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .ack_o       (ack_o),
        .rdata_o     (rdata_o),
        .busy_o      (busy_o),
        .grant_id_o  (grant_id_o),
        .transfer    (transfer),
        .write       (write),
        .addr        (addr),
        .wdata       (wdata),
        .ready       (ready),
        .rdata       (rdata)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int            id;
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            n_ack = 0;
    int            served[$];
    logic [DW-1:0] last_ack_rdata = '0;

    bit [N-1:0]    pend = '0;
    bit            pw[N];
    logic [AW-1:0] pa[N];
    logic [DW-1:0] pd[N];
    int            model_last = N - 1;
    logic [DW-1:0] model_mem[logic [AW-1:0]];
    logic [DW-1:0] slave_mem[logic [AW-1:0]];
    int            slave_delay_force = 0;
    int            stray_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void apply_one(input int k);
        req_write_i[k]          = pw[k];
        req_addr_i[k*AW +: AW]  = pa[k];
        req_wdata_i[k*DW +: DW] = pd[k];
    endfunction

    function automatic void apply();
        for (int k = 0; k < N; k++) apply_one(k);
        req_i = pend;
    endfunction

    function automatic void new_req(input int k);
        pend[k] = 1'b1;
        pw[k]   = 1'($urandom_range(0, 1));
        pa[k]   = 32'h1000_0000 + 32'(4 * $urandom_range(0, 7));
        pd[k]   = $urandom;
    endfunction

    // Round robin: first pending requester strictly after the last one served.
    function automatic int model_pick();
        for (int off = 1; off <= N; off++) begin
            int k;
            k = (model_last + off) % N;
            if (pend[k]) return k;
        end
        return -1;
    endfunction

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_transfer"}, transfer, 0);
        chk({tag, "_write"}, write, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_ack"}, ack_o, 0);
        chk({tag, "_rdata"}, rdata_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_grant"}, grant_id_o, 0);
    endtask

    // mode 0: plain; 1: disturb inputs during WAIT; 2: reset during WAIT.
    task automatic serve_one(input int mode, output int who);
        int   w;
        bit   got;
        bit   aborted;
        exp_t e;
        apply();
        w = model_pick();
        who = w;
        if (w < 0) return;
        e.id = w; e.wr = pw[w]; e.a = pa[w]; e.d = pd[w];
        if (pw[w]) begin
            e.rd = ~pa[w];
            model_mem[pa[w]] = pd[w];
        end else begin
            e.rd = model_mem.exists(pa[w]) ? model_mem[pa[w]] : '0;
        end
        exp_q.push_back(e);
        model_last = w;
        if (mode == 1) slave_delay_force = 5;
        if (mode == 2) slave_delay_force = 6;
        got = 0;
        aborted = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge PCLK); #1;
            if (c == 0) chk("transfer_latency", transfer, 1);
            if (mode == 1 && c == 2) begin
                pend[3] = 1'b1; pw[3] = 1'b0; pa[3] = 32'h1000_001C; pd[3] = $urandom;
                apply_one(3);
                req_i[3] = 1'b1;
                req_addr_i[AW-1:0] = 32'hBAD0_0000;
            end
            if (mode == 2 && c == 3) begin
                new_req(0);
                apply();
                #1 PRESET = 1'b1;
                #1 chk_reset_outs("midreset");
                exp_q.delete();
                model_last = N - 1;
                repeat (3) @(posedge PCLK);
                @(negedge PCLK);
                PRESET = 1'b0;
                slave_delay_force = 0;
                aborted = 1;
                break;
            end
            if (ack_o != '0) begin
                got = 1;
                break;
            end
        end
        if (aborted) return;
        slave_delay_force = 0;
        chk("ack_timeout", got, 1);
        @(posedge PCLK); #1;
        pend[w] = 1'b0;
        apply();
    endtask

    // Behavioural APB slave: reads return memory, writes return ~addr.
    initial begin
        int            stray_done;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            wr;
        bit            abort;
        int            dl;
        stray_done = 0;
        ready = 1'b0;
        rdata = '0;
        forever begin
            @(posedge PCLK); #1;
            if (stray_cnt != stray_done) begin
                stray_done++;
                ready = 1'b1;
                rdata = 32'hDEAD_BEEF;
                @(posedge PCLK); #1;
                ready = 1'b0;
            end else if (transfer && !PRESET) begin
                a = addr; d = wdata; wr = write;
                dl = (slave_delay_force > 0) ? slave_delay_force : int'($urandom_range(1, 3));
                abort = 0;
                for (int i = 0; i < dl; i++) begin
                    @(posedge PCLK); #1;
                    if (PRESET) abort = 1;
                end
                if (!abort) begin
                    if (wr) begin
                        rdata = ~a;
                        slave_mem[a] = d;
                    end else begin
                        rdata = slave_mem.exists(a) ? slave_mem[a] : '0;
                    end
                    ready = 1'b1;
                    @(posedge PCLK); #1;
                    ready = 1'b0;
                end
            end
        end
    end

    // Monitor: checks the master port on transfer, latched values while busy,
    // and pops the scoreboard on every ack.
    initial begin
        exp_t cur;
        exp_t e;
        bit   inflight;
        inflight = 0;
        forever begin
            @(posedge PCLK); #1;
            if (PRESET) begin
                inflight = 0;
            end else begin
                if (transfer) begin
                    if (exp_q.size() == 0) begin
                        chk("transfer_unexpected", transfer, 0);
                    end else begin
                        cur = exp_q[0];
                        inflight = 1;
                        chk("xfer_addr", addr, cur.a);
                        chk("xfer_write", write, cur.wr);
                        chk("xfer_wdata", wdata, cur.d);
                        chk("xfer_grant", grant_id_o, cur.id);
                        chk("xfer_busy", busy_o, 1);
                    end
                end else if (inflight && busy_o) begin
                    chk("held_addr", addr, cur.a);
                    chk("held_grant", grant_id_o, cur.id);
                end
                if (ack_o != '0) begin
                    n_ack++;
                    if (exp_q.size() == 0) begin
                        chk("ack_unexpected", ack_o, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_vector", ack_o, 64'(1) << e.id);
                        chk("ack_rdata", rdata_o, e.rd);
                        chk("ack_busy", busy_o, 1);
                        served.push_back(e.id);
                        last_ack_rdata = rdata_o;
                    end
                    inflight = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int who;
        int base;
        int acks_before;
        int fair_exp[5] = '{0, 1, 2, 3, 0};

        PRESET = 1'b1;
        for (int k = 0; k < N; k++) begin pw[k] = 0; pa[k] = '0; pd[k] = '0; end
        apply();
        repeat (3) @(posedge PCLK);
        #1 chk_reset_outs("reset");
        @(negedge PCLK);
        PRESET = 1'b0;

        // Single write then read-back from requester 0.
        pend[0] = 1; pw[0] = 1; pa[0] = 32'h1000_0000; pd[0] = 32'd10;
        serve_one(0, who);
        pend[0] = 1; pw[0] = 0;
        serve_one(0, who);
        chk("read_back", last_ack_rdata, 10);

        // Serve requester 3 so the next round starts at 0.
        pend[3] = 1; pw[3] = 0; pa[3] = 32'h1000_000C; pd[3] = '0;
        serve_one(0, who);

        // Fairness with all four requesting and re-requesting.
        for (int k = 0; k < N; k++) begin
            new_req(k);
            pa[k] = 32'h1000_0000 + 32'(4 * k);
        end
        base = served.size();
        for (int t = 0; t < 5; t++) begin
            serve_one(0, who);
            if (who >= 0 && t < 4) begin
                pend[who] = 1; pw[who] = 1'($urandom_range(0, 1)); pd[who] = $urandom;
            end
        end
        chk("fair_count", served.size() - base, 5);
        if (served.size() - base >= 5)
            for (int i = 0; i < 5; i++) chk("fair_order", served[base + i], fair_exp[i]);
        while (pend != '0) serve_one(0, who);

        // Wrap-around: serve 2, then only 0 and 1 pending.
        pend = '0;
        new_req(2);
        serve_one(0, who);
        new_req(0); new_req(1);
        base = served.size();
        serve_one(0, who);
        serve_one(0, who);
        chk("wrap_count", served.size() - base, 2);
        if (served.size() - base >= 2) begin
            chk("wrap_first", served[base], 0);
            chk("wrap_second", served[base + 1], 1);
        end

        // Stray ready while idle must not ack.
        repeat (2) @(posedge PCLK);
        acks_before = n_ack;
        stray_cnt++;
        repeat (5) @(posedge PCLK);
        #1 chk("stray_ready_ack", n_ack - acks_before, 0);

        // Inputs disturbed during WAIT; requester 3 follows only after DONE.
        new_req(0);
        base = served.size();
        serve_one(1, who);
        serve_one(0, who);
        chk("latch_count", served.size() - base, 2);
        if (served.size() - base >= 2) chk("late_req3", served[base + 1], 3);

        // Reset in the middle of a read from requester 1.
        new_req(1); pw[1] = 0;
        acks_before = n_ack;
        serve_one(2, who);
        chk("midreset_no_ack", n_ack - acks_before, 0);
        base = served.size();
        serve_one(0, who);
        chk("post_reset_first", who, 0);
        if (served.size() > base) chk("post_reset_served", served[base], 0);
        serve_one(0, who);

        // Randomized traffic.
        for (int t = 0; t < 80; t++) begin
            if (pend == '0) begin
                for (int k = 0; k < N; k++) if ($urandom_range(0, 1) == 1) new_req(k);
                if (pend == '0) new_req(int'($urandom_range(0, N - 1)));
            end
            serve_one(0, who);
            for (int k = 0; k < N; k++) if (!pend[k] && $urandom_range(0, 2) == 0) new_req(k);
        end
        while (pend != '0) serve_one(0, who);

        repeat (5) @(posedge PCLK);
        #1 chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
